// File: rtl/calc_engine.sv
// calc_engine: sequential keypad calculator core.
// Builds signed operands from eBCD key codes, runs an entry FSM and drives the
// display value/selector and error flags. Add/sub finish in one cycle; mul,
// div and mod use a shared WIDTH-step shift unit.
// Optional feature macro: CALC_CHAIN_EN (operator key during op2 entry
// evaluates the pending operation and chains the result as the next op1).
module calc_engine #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic             key_vld,
  input  logic [4:0]       key_code,
  output logic             key_rdy,
  output logic [WIDTH-1:0] disp_val,
  output logic [1:0]       disp_sel,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(WIDTH + 1) + 1;
  localparam int EW = WIDTH + 4;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD} op_e;

  state_e             state_q, state_d;
  op_e                opr_q, opr_d, nxt_q, nxt_d;
  logic               chain_q, chain_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [IW-1:0]      it_q, it_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [1:0]         errc_q, errc_d;

  // Key decode and entry arithmetic
  logic             is_digit, is_op, is_eq, is_clr, is_bs, digit_ok;
  logic [3:0]       digit;
  op_e              key_op;
  logic [EW-1:0]    ext;

  // Shift unit and result formation
  logic [WIDTH:0]     madd, dsh;
  logic               dge, neg;
  logic [WIDTH-1:0]   dsub, lo, hi, sum, dif;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   fin_val;
  logic               fin_ov;
  logic               done, done_ov;
  logic [WIDTH-1:0]   done_val;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Decode the key code and pre-compute the appended-digit entry value
  always_comb begin
    is_digit = (key_code < 5'd10);
    is_op    = (key_code >= 5'd10) && (key_code <= 5'd14);
    is_eq    = (key_code == 5'd15);
    is_clr   = (key_code == 5'd16);
    is_bs    = (key_code == 5'd17);
    digit    = key_code[3:0];
    // codes 10..14 have low bits 2..6, so subtracting 2 yields the op index
    key_op   = op_e'(key_code[2:0] - 3'd2);
    ext      = {4'b0, val_q} * EW'(10) + {{(EW-4){1'b0}}, digit};
    digit_ok = (cnt_q != CW'(DIGITS)) && (ext <= {4'b0, MAX_POS});
  end

  // One step of shift-add multiply / restoring divide, plus final result forming
  always_comb begin
    madd = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, bmag_q} : '0);
    dsh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    dge  = (dsh >= {1'b0, bmag_q});
    dsub = dge ? WIDTH'(dsh - {1'b0, bmag_q}) : dsh[WIDTH-1:0];
    step = (opr_q == OP_MUL) ? {madd, prod_q[WIDTH-1:1]}
                             : {dsub, prod_q[WIDTH-2:0], dge};
    neg  = sa_q ^ sb_q;
    lo   = step[WIDTH-1:0];
    hi   = step[2*WIDTH-1:WIDTH];
    sum  = op1_q + op2_q;
    dif  = op1_q - op2_q;
    fin_val = '0;
    fin_ov  = 1'b0;
    case (opr_q)
      OP_ADD: begin
        fin_val = sum;
        fin_ov  = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (sum[WIDTH-1] != op1_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_val = dif;
        fin_ov  = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (dif[WIDTH-1] != op1_q[WIDTH-1]);
      end
      OP_MUL: begin
        fin_val = neg ? -lo : lo;
        fin_ov  = (hi != '0) || (neg ? (lo > MIN_MAG) : lo[WIDTH-1]);
      end
      OP_DIV: begin
        fin_val = neg ? -lo : lo;
        fin_ov  = !neg && lo[WIDTH-1];
      end
      default: begin
        fin_val = sa_q ? -hi : hi;
        fin_ov  = 1'b0;
      end
    endcase
  end

  // Entry FSM next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    opr_d    = opr_q;
    nxt_d    = nxt_q;
    chain_d  = chain_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    res_d    = res_q;
    bmag_d   = bmag_q;
    prod_d   = prod_q;
    it_d     = it_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    errc_d   = errc_q;
    done     = 1'b0;
    done_ov  = 1'b0;
    done_val = '0;
    case (state_q)
      S_A, S_B: begin
        if (key_vld) begin
          if (is_digit && digit_ok) begin
            val_d = ext[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
          end else if (is_bs) begin
            val_d = val_q / WIDTH'(10);
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          end else if (is_op && state_q == S_A) begin
            op1_d   = val_q;
            opr_d   = key_op;
            val_d   = '0;
            cnt_d   = '0;
            state_d = S_OP;
          end else if (is_eq && state_q == S_B) begin
            op2_d   = val_q;
            val_d   = '0;
            cnt_d   = '0;
            it_d    = '0;
            state_d = S_EXEC;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            op2_d   = val_q;
            nxt_d   = key_op;
            chain_d = 1'b1;
            val_d   = '0;
            cnt_d   = '0;
            it_d    = '0;
            state_d = S_EXEC;
          end
`endif
        end
      end
      S_OP: begin
        if (key_vld) begin
          if (is_digit) begin
            val_d   = WIDTH'(digit);
            cnt_d   = CW'(1);
            state_d = S_B;
          end else if (is_op) begin
            opr_d = key_op;
          end
        end
      end
      S_RES: begin
        if (key_vld) begin
          if (is_digit) begin
            val_d   = WIDTH'(digit);
            cnt_d   = CW'(1);
            state_d = S_A;
          end else if (is_op) begin
            op1_d   = res_q;
            opr_d   = key_op;
            state_d = S_OP;
          end else if (is_eq) begin
            op1_d   = res_q;
            it_d    = '0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (it_q == '0) begin
          if (opr_q == OP_ADD || opr_q == OP_SUB) begin
            done     = 1'b1;
            done_val = fin_val;
            done_ov  = fin_ov;
          end else if ((opr_q == OP_DIV || opr_q == OP_MOD) && op2_q == '0) begin
            errc_d  = 2'd1;
            chain_d = 1'b0;
            state_d = S_ERR;
          end else begin
            prod_d = {{WIDTH{1'b0}}, mag(op1_q)};
            bmag_d = mag(op2_q);
            sa_d   = op1_q[WIDTH-1];
            sb_d   = op2_q[WIDTH-1];
            it_d   = IW'(1);
          end
        end else begin
          prod_d = step;
          if (it_q == IW'(WIDTH)) begin
            done     = 1'b1;
            done_val = fin_val;
            done_ov  = fin_ov;
          end else begin
            it_d = it_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (done) begin
      if (done_ov) begin
        errc_d  = 2'd2;
        chain_d = 1'b0;
        state_d = S_ERR;
      end else if (chain_q) begin
        op1_d   = done_val;
        res_d   = done_val;
        opr_d   = nxt_q;
        chain_d = 1'b0;
        state_d = S_OP;
      end else begin
        res_d   = done_val;
        state_d = S_RES;
      end
    end
    if (key_vld && is_clr) begin
      state_d = S_A;
      opr_d   = OP_ADD;
      nxt_d   = OP_ADD;
      chain_d = 1'b0;
      val_d   = '0;
      cnt_d   = '0;
      op1_d   = '0;
      op2_d   = '0;
      res_d   = '0;
      bmag_d  = '0;
      prod_d  = '0;
      it_d    = '0;
      sa_d    = 1'b0;
      sb_d    = 1'b0;
      errc_d  = 2'd0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state_q <= S_A;
      opr_q   <= OP_ADD;
      nxt_q   <= OP_ADD;
      chain_q <= 1'b0;
      val_q   <= '0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      bmag_q  <= '0;
      prod_q  <= '0;
      it_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      errc_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      nxt_q   <= nxt_d;
      chain_q <= chain_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      bmag_q  <= bmag_d;
      prod_q  <= prod_d;
      it_q    <= it_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      errc_q  <= errc_d;
    end
  end

  // Display and status outputs derived from the current state
  always_comb begin
    key_rdy  = (state_q != S_EXEC) && (state_q != S_ERR);
    busy     = (state_q == S_EXEC);
    err      = (state_q == S_ERR);
    err_code = errc_q;
    disp_val = '0;
    disp_sel = 2'd0;
    case (state_q)
      S_A:    begin disp_val = val_q; disp_sel = 2'd0; end
      S_OP:   begin disp_val = op1_q; disp_sel = 2'd1; end
      S_B:    begin disp_val = val_q; disp_sel = 2'd2; end
      S_EXEC: begin disp_val = op2_q; disp_sel = 2'd2; end
      S_RES:  begin disp_val = res_q; disp_sel = 2'd3; end
      default: begin disp_val = '0; disp_sel = 2'd3; end
    endcase
  end

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine (WIDTH=32, DIGITS=8): stimulus pushes
// expected results/state snapshots; a negedge monitor pops and compares.
module tb_calc_engine;

  localparam int W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          sw_clk = 1'b0;
  logic          rst;
  logic          key_vld;
  logic [4:0]    key_code;
  logic          key_rdy;
  logic [W-1:0]  disp_val;
  logic [1:0]    disp_sel;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;

  calc_engine #(.WIDTH(W), .DIGITS(8)) dut (
    .sw_clk(sw_clk), .rst(rst), .key_vld(key_vld), .key_code(key_code),
    .key_rdy(key_rdy), .disp_val(disp_val), .disp_sel(disp_sel),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 sw_clk = ~sw_clk;

  typedef struct {
    logic [W-1:0] val; logic [1:0] sel; logic e; logic [1:0] ec; int blen; bit chk_sel;
  } res_t;
  typedef struct {
    logic [W-1:0] val; logic [1:0] sel; logic e; logic [1:0] ec; logic b; logic rdy; bit chk_sel;
  } probe_t;

  res_t   rq[$];
  probe_t pq[$];
  int n_vec = 0;
  int n_mis = 0;
  int bcnt = 0;
  int wait_cyc = 0;
  bit bprev = 1'b0;
  res_t   mr;
  probe_t mp;

  // reference model state
  longint m_res;
  int     m_op;
  longint m_b;
  bit     m_have = 1'b0;
  bit     m_err  = 1'b0;

  // Monitor: state snapshots on the next negedge, results when busy falls
  always @(negedge sw_clk) begin
    if (pq.size() > 0) begin
      mp = pq.pop_front();
      n_vec++;
      if (disp_val !== mp.val || err !== mp.e || err_code !== mp.ec || busy !== mp.b ||
          key_rdy !== mp.rdy || (mp.chk_sel && disp_sel !== mp.sel)) begin
        n_mis++;
        $display("FAIL state: got val=%0d sel=%0d err=%0b code=%0d busy=%0b rdy=%0b, want val=%0d sel=%0d err=%0b code=%0d busy=%0b rdy=%0b",
                 $signed(disp_val), disp_sel, err, err_code, busy, key_rdy,
                 $signed(mp.val), mp.sel, mp.e, mp.ec, mp.b, mp.rdy);
      end
    end
    if (busy === 1'b1) bcnt++;
    else if (bprev) begin
      n_vec++;
      if (rq.size() == 0) begin
        n_mis++;
        $display("FAIL result: unexpected busy fall, got val=%0d busy_len=%0d, want no result", $signed(disp_val), bcnt);
      end else begin
        mr = rq.pop_front();
        if (disp_val !== mr.val || err !== mr.e || err_code !== mr.ec || bcnt != mr.blen ||
            (mr.chk_sel && disp_sel !== mr.sel)) begin
          n_mis++;
          $display("FAIL result: got val=%0d sel=%0d err=%0b code=%0d busy_len=%0d, want val=%0d sel=%0d err=%0b code=%0d busy_len=%0d",
                   $signed(disp_val), disp_sel, err, err_code, bcnt,
                   $signed(mr.val), mr.sel, mr.e, mr.ec, mr.blen);
        end
      end
      bcnt = 0;
    end
    bprev = (busy === 1'b1);
    if (rq.size() > 0) begin
      wait_cyc++;
      if (wait_cyc > 200) begin
        n_vec++;
        n_mis++;
        $display("FAIL timeout: got no result within 200 cycles, want %0d pending", rq.size());
        rq.delete();
        wait_cyc = 0;
      end
    end else wait_cyc = 0;
  end

  function automatic longint p10(input int n);
    longint v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  function automatic longint rand_num(input int maxlen);
    int len = $urandom_range(1, maxlen);
    return longint'({32'd0, $urandom()}) % p10(len);
  endfunction

  // Reference arithmetic: plain 64-bit math, then range check
  function automatic void calc(input longint a, input int op, input longint b,
                               output longint r, output int ec);
    ec = 0;
    r  = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: if (b == 0) ec = 1; else r = a / b;
      default: if (b == 0) ec = 1; else r = a % b;
    endcase
    if (ec == 0 && (r > MAXV || r < MINV)) ec = 2;
    if (ec != 0) r = 0;
  endfunction

  task automatic press(input int k);
    @(posedge sw_clk); #1;
    key_vld = 1'b1;
    key_code = 5'(k);
    @(posedge sw_clk); #1;
    key_vld = 1'b0;
  endtask

  task automatic enter_num(input longint v);
    int d[$];
    longint t = v;
    if (t == 0) d.push_back(0);
    while (t > 0) begin
      d.push_front(int'(t % 10));
      t = t / 10;
    end
    foreach (d[i]) press(d[i]);
  endtask

  task automatic push_res(input longint v, input int sel, input bit e, input int ec,
                          input int blen, input bit chk_sel);
    res_t x;
    x.val = W'(v); x.sel = 2'(sel); x.e = e; x.ec = 2'(ec); x.blen = blen; x.chk_sel = chk_sel;
    rq.push_back(x);
  endtask

  task automatic probe(input longint v, input int sel, input bit e, input int ec,
                       input bit b, input bit rdy, input bit chk_sel);
    probe_t x;
    x.val = W'(v); x.sel = 2'(sel); x.e = e; x.ec = 2'(ec); x.b = b; x.rdy = rdy; x.chk_sel = chk_sel;
    pq.push_back(x);
  endtask

  task automatic probe_reset();
    probe(0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && rq.size() != 0; i++) @(posedge sw_clk);
    #1;
  endtask

  task automatic model_update(input int op, input longint b, input longint r, input int ec);
    if (ec != 0) begin
      m_err  = 1'b1;
      m_have = 1'b0;
    end else begin
      m_res  = r;
      m_op   = op;
      m_b    = b;
      m_have = 1'b1;
    end
  endtask

  task automatic expect_calc(input longint a, input int op, input longint b);
    longint r;
    int ec;
    calc(a, op, b, r, ec);
    push_res(r, 3, ec != 0, ec, (ec == 1 || op < 2) ? 1 : W + 1, ec == 0);
    press(15);
    drain();
    model_update(op, b, r, ec);
  endtask

  task automatic apply(input longint a, input int op, input longint b);
    press(10 + op);
    enter_num(b);
    expect_calc(a, op, b);
  endtask

  task automatic fresh_calc(input longint a, input int op, input longint b);
    if (m_err) begin
      press(16);
      m_err = 1'b0;
    end
    enter_num(a);
    apply(a, op, b);
  endtask

  task automatic from_res(input int op, input longint b);
    apply(m_res, op, b);
  endtask

  task automatic again();
    expect_calc(m_res, m_op, m_b);
  endtask

  initial begin
    rst = 1'b1;
    key_vld = 1'b0;
    key_code = '0;
    repeat (3) @(posedge sw_clk);
    #1 rst = 1'b0;
    probe_reset();

    fresh_calc(12, 0, 30);
    fresh_calc(7, 1, 9);
    from_res(2, 6);

    // digit-count limit and backspace
    press(16); m_have = 1'b0;
    enter_num(64'd2147483647);
    probe(21474836, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    press(17);
    probe(2147483, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    press(16);
    probe_reset();

    // divide by zero, dropped key in error, clear
    fresh_calc(5, 3, 0);
    press(3);
    probe(0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    press(16); m_err = 1'b0;
    probe_reset();

    fresh_calc(99999, 2, 99999);
    fresh_calc(0, 1, 7);
    from_res(4, 2);
    fresh_calc(0, 1, 7);
    from_res(3, 2);

    // signed range boundaries
    fresh_calc(0, 1, 65536);
    from_res(2, 32768);
    from_res(3, 1);
    from_res(1, 1);
    fresh_calc(0, 1, 65536);
    from_res(2, 32769);
    fresh_calc(65536, 2, 32768);
    fresh_calc(99999999, 2, 21);
    from_res(0, 99999999);
    fresh_calc(1, 2, 0);
    fresh_calc(100, 4, 7);
    again();
    fresh_calc(1000, 3, 3);
    again();

    // operator key during op2 entry
    press(16); m_err = 1'b0;
    press(2); press(10); press(3);
`ifdef CALC_CHAIN_EN
    push_res(5, 1, 1'b0, 0, 1, 1'b1);
    press(12);
    drain();
    press(4);
    push_res(20, 3, 1'b0, 0, W + 1, 1'b1);
    press(15);
    drain();
    model_update(2, 4, 20, 0);
`else
    press(12);
    probe(3, 2, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    push_res(5, 3, 1'b0, 0, 1, 1'b1);
    press(15);
    drain();
    model_update(0, 3, 5, 0);
`endif

    // clear during the 10th busy cycle of a multiply
    press(16);
    enter_num(123); press(12); enter_num(456);
    push_res(0, 0, 1'b0, 0, 10, 1'b1);
    press(15);
    repeat (9) @(posedge sw_clk);
    #1 key_vld = 1'b1; key_code = 5'd16;
    @(posedge sw_clk); #1 key_vld = 1'b0;
    probe_reset();
    drain();
    m_have = 1'b0; m_err = 1'b0;

    // reset during a divide
    enter_num(7); press(13); enter_num(3);
    push_res(0, 0, 1'b0, 0, 5, 1'b1);
    press(15);
    repeat (4) @(posedge sw_clk);
    #1 rst = 1'b1;
    @(posedge sw_clk); #1 rst = 1'b0;
    probe_reset();
    drain();

    // randomized sequences
    for (int n = 0; n < 60; n++) begin
      int sel_m = $urandom_range(0, 9);
      int op = $urandom_range(0, 4);
      longint b = ($urandom_range(0, 7) == 0) ? 0 : rand_num(5);
      if (m_have && sel_m < 3) again();
      else if (m_have && sel_m < 6) from_res(op, b);
      else fresh_calc(rand_num(8), op, b);
    end

    drain();
    repeat (3) @(posedge sw_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
